// File: rtl/pipearch_c1_ccip_pkg.sv
// -----------------------------------------------------------------------------
// pipearch_c1_ccip_pkg
// Minimal CCI-P c1 (write) channel types used by pipearch_c1_arbiter.
// Field layout follows the CCI-P c1 request/response headers:
//   t_cci_c1_ReqMemHdr : write request header (80 bits)
//   t_cci_c1_RspMemHdr : write response header (28 bits)
//   t_if_ccip_c1_Tx    : {hdr, 512-bit data, valid}
//   t_if_ccip_c1_Rx    : {hdr, rspValid}
// -----------------------------------------------------------------------------
package pipearch_c1_ccip_pkg;

    localparam logic [3:0] eREQ_WRLINE_I = 4'h0;
    localparam logic [3:0] eREQ_WRLINE_M = 4'h1;
    localparam logic [3:0] eRSP_WRLINE   = 4'h1;
    localparam logic [3:0] eRSP_WRFENCE  = 4'h4;
    localparam logic [1:0] eCL_LEN_1     = 2'b00;

    typedef struct packed {
        logic [5:0]  rsvd2;
        logic [1:0]  vc_sel;
        logic        sop;
        logic        rsvd1;
        logic [1:0]  cl_len;
        logic [3:0]  req_type;
        logic [5:0]  rsvd0;
        logic [41:0] address;
        logic [15:0] mdata;
    } t_cci_c1_ReqMemHdr;

    typedef struct packed {
        logic [1:0]  vc_used;
        logic        rsvd1;
        logic        hit_miss;
        logic        format;
        logic        rsvd0;
        logic [1:0]  cl_num;
        logic [3:0]  resp_type;
        logic [15:0] mdata;
    } t_cci_c1_RspMemHdr;

    typedef struct packed {
        t_cci_c1_ReqMemHdr hdr;
        logic [511:0]      data;
        logic              valid;
    } t_if_ccip_c1_Tx;

    typedef struct packed {
        t_cci_c1_RspMemHdr hdr;
        logic              rspValid;
    } t_if_ccip_c1_Rx;

endpackage

// File: rtl/pipearch_c1_arbiter.sv
// -----------------------------------------------------------------------------
// pipearch_c1_arbiter
// Shares one CCI-P c1 write channel between NUM_REQ write engines.
// One single-line write is granted per cycle (round-robin), tagged with the
// requester index in mdata[TAG_LSB+3:TAG_LSB] and registered onto the Tx port.
// Write acks are routed back to the requester named by the tag, and a
// per-requester count of issued-but-unacked writes is maintained.
//
// Ports:
//   clk, reset         clock, synchronous active-high reset
//   wr_valid[i]        requester i presents a write (held until granted)
//   wr_hdr[i]          write header from requester i
//   wr_data[i]         cache-line payload from requester i
//   wr_grant[i]        combinational one-hot grant
//   wr_ack[i]          one-cycle ack pulse for requester i
//   wr_outstanding[i]  issued-but-unacked write count
//   wr_drained[i]      wr_outstanding[i] == 0
//   tag_error          sticky: illegal or unmatched write ack seen
//   c1TxAlmFull        c1 Tx almost-full; blocks new grants
//   cp2af_sRx_c1       write responses from the platform
//   af2cp_sTx_c1       registered write requests to the platform
// -----------------------------------------------------------------------------
module pipearch_c1_arbiter
    import pipearch_c1_ccip_pkg::*;
#(
    parameter int NUM_REQ         = 2,
    parameter int MAX_OUTSTANDING = 512,
    parameter int TAG_LSB         = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_REQ-1:0] wr_valid,
    input  t_cci_c1_ReqMemHdr wr_hdr [NUM_REQ],
    input  logic [511:0]      wr_data [NUM_REQ],
    output logic [NUM_REQ-1:0] wr_grant,
    output logic [NUM_REQ-1:0] wr_ack,
    output logic [15:0]       wr_outstanding [NUM_REQ],
    output logic [NUM_REQ-1:0] wr_drained,
    output logic              tag_error,
    input  logic              c1TxAlmFull,
    input  t_if_ccip_c1_Rx    cp2af_sRx_c1,
    output t_if_ccip_c1_Tx    af2cp_sTx_c1
);

    localparam int          RR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [15:0] CAP  = 16'(MAX_OUTSTANDING);

    logic [RR_W-1:0]   rr_q, rr_d;
    logic [NUM_REQ-1:0] eligible;
    logic [NUM_REQ-1:0] grant_oh;
    logic              grant_any;
    logic [3:0]        grant_idx;

    logic              tx_valid_q;
    t_cci_c1_ReqMemHdr tx_hdr_q, tx_hdr_d;
    logic [511:0]      tx_data_q, tx_data_d;

    logic              rsp_wr;
    logic [3:0]        rsp_tag;
    logic [NUM_REQ-1:0] ack_hit;
    logic              rsp_bad;
    logic [NUM_REQ-1:0] wr_ack_q;
    logic              tag_error_q;

    // Only a few response fields matter here; fold the rest into a sink.
    logic              unused_rx;
    assign unused_rx = ^cp2af_sRx_c1;

    // ---------------------------------------------------------------------
    // Response decode: a write ack is legal only if it names an existing
    // requester that actually has a write in flight.
    // ---------------------------------------------------------------------
    assign rsp_wr  = cp2af_sRx_c1.rspValid &&
                     (cp2af_sRx_c1.hdr.resp_type == eRSP_WRLINE);
    assign rsp_tag = cp2af_sRx_c1.hdr.mdata[TAG_LSB +: 4];
    assign rsp_bad = rsp_wr && (ack_hit == '0);

    // ---------------------------------------------------------------------
    // Per-requester outstanding counters and eligibility
    // ---------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
            logic [15:0] cnt_q, cnt_d;

            assign eligible[gi] = wr_valid[gi] && (cnt_q < CAP) &&
                                  !c1TxAlmFull && !reset;
            assign ack_hit[gi]  = rsp_wr && (rsp_tag == 4'(gi)) &&
                                  (cnt_q != 16'd0);

            // Grant and ack in the same cycle cancel out.
            assign cnt_d = cnt_q + {15'd0, grant_oh[gi]} - {15'd0, ack_hit[gi]};

            always_ff @(posedge clk) begin
                if (reset) begin
                    cnt_q <= 16'd0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end

            assign wr_outstanding[gi] = cnt_q;
            assign wr_drained[gi]     = (cnt_q == 16'd0);
        end
    endgenerate

    // ---------------------------------------------------------------------
    // Round-robin pick: first pass covers rr..NUM_REQ-1, second pass wraps
    // around to 0..rr-1, so the search order is rr, rr+1, ... mod NUM_REQ.
    // ---------------------------------------------------------------------
    always_comb begin
        grant_oh  = '0;
        grant_any = 1'b0;
        grant_idx = 4'd0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!grant_any && eligible[i] && (i >= int'(rr_q))) begin
                grant_oh[i] = 1'b1;
                grant_any   = 1'b1;
                grant_idx   = 4'(i);
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!grant_any && eligible[i]) begin
                grant_oh[i] = 1'b1;
                grant_any   = 1'b1;
                grant_idx   = 4'(i);
            end
        end
    end

    always_comb begin
        rr_d = rr_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_oh[i]) begin
                rr_d = (i == NUM_REQ - 1) ? '0 : RR_W'(i + 1);
            end
        end
    end

    // ---------------------------------------------------------------------
    // Tx request staging: capture the granted header/data, stamping the
    // requester index into the tag field. Without a grant, hold last value.
    // ---------------------------------------------------------------------
    always_comb begin
        tx_hdr_d  = tx_hdr_q;
        tx_data_d = tx_data_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_oh[i]) begin
                tx_hdr_d  = wr_hdr[i];
                tx_data_d = wr_data[i];
            end
        end
        if (grant_any) begin
            tx_hdr_d.mdata[TAG_LSB +: 4] = grant_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_q        <= '0;
            tx_valid_q  <= 1'b0;
            wr_ack_q    <= '0;
            tag_error_q <= 1'b0;
        end else begin
            rr_q        <= rr_d;
            tx_valid_q  <= grant_any;
            wr_ack_q    <= ack_hit;
            tag_error_q <= tag_error_q | rsp_bad;
        end
    end

    // Payload registers carry no reset; valid qualifies them.
    always_ff @(posedge clk) begin
        tx_hdr_q  <= tx_hdr_d;
        tx_data_q <= tx_data_d;
    end

    assign wr_grant           = grant_oh;
    assign wr_ack             = wr_ack_q;
    assign tag_error          = tag_error_q;
    assign af2cp_sTx_c1.valid = tx_valid_q;
    assign af2cp_sTx_c1.hdr   = tx_hdr_q;
    assign af2cp_sTx_c1.data  = tx_data_q;

endmodule

// File: tb/tb_pipearch_c1_arbiter.sv
// -----------------------------------------------------------------------------
// tb_pipearch_c1_arbiter
// Directed bench for pipearch_c1_arbiter. Two instances share stimulus:
//   dut_a : NUM_REQ=2, MAX_OUTSTANDING=8 (streaming, fairness, errors)
//   dut_b : NUM_REQ=2, MAX_OUTSTANDING=2 (outstanding cap)
// Inputs change 1 time unit after the rising edge; outputs are checked one
// further time unit later.
// -----------------------------------------------------------------------------
module tb_pipearch_c1_arbiter;
    import pipearch_c1_ccip_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset;
    logic [1:0]        wr_valid;
    t_cci_c1_ReqMemHdr wr_hdr [2];
    logic [511:0]      wr_data [2];
    logic              almfull;
    t_if_ccip_c1_Rx    rx;

    logic [1:0]     grant_a, ack_a, drained_a;
    logic [15:0]    outs_a [2];
    logic           terr_a;
    t_if_ccip_c1_Tx tx_a;

    logic [1:0]     grant_b, ack_b, drained_b;
    logic [15:0]    outs_b [2];
    logic           terr_b;
    t_if_ccip_c1_Tx tx_b;

    int tests;
    int fails;

    pipearch_c1_arbiter #(.NUM_REQ(2), .MAX_OUTSTANDING(8), .TAG_LSB(12)) dut_a (
        .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_hdr(wr_hdr),
        .wr_data(wr_data), .wr_grant(grant_a), .wr_ack(ack_a),
        .wr_outstanding(outs_a), .wr_drained(drained_a), .tag_error(terr_a),
        .c1TxAlmFull(almfull), .cp2af_sRx_c1(rx), .af2cp_sTx_c1(tx_a)
    );

    pipearch_c1_arbiter #(.NUM_REQ(2), .MAX_OUTSTANDING(2), .TAG_LSB(12)) dut_b (
        .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_hdr(wr_hdr),
        .wr_data(wr_data), .wr_grant(grant_b), .wr_ack(ack_b),
        .wr_outstanding(outs_b), .wr_drained(drained_b), .tag_error(terr_b),
        .c1TxAlmFull(almfull), .cp2af_sRx_c1(rx), .af2cp_sTx_c1(tx_b)
    );

    function automatic t_cci_c1_ReqMemHdr mk_hdr(input logic [15:0] md,
                                                 input logic [41:0] addr);
        t_cci_c1_ReqMemHdr h;
        h          = '0;
        h.req_type = eREQ_WRLINE_I;
        h.cl_len   = eCL_LEN_1;
        h.sop      = 1'b1;
        h.address  = addr;
        h.mdata    = md;
        return h;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rsp(input logic v, input logic [3:0] rtype,
                           input logic [15:0] md);
        rx               = '0;
        rx.rspValid      = v;
        rx.hdr.resp_type = rtype;
        rx.hdr.mdata     = md;
    endtask

    task automatic idle_inputs();
        wr_valid   = 2'b00;
        almfull    = 1'b0;
        wr_hdr[0]  = mk_hdr(16'h0005, 42'h100);
        wr_hdr[1]  = mk_hdr(16'h0007, 42'h200);
        wr_data[0] = '0;
        wr_data[1] = '0;
        set_rsp(1'b0, 4'h0, 16'h0000);
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        cyc();
        cyc();
        reset = 1'b0;
    endtask

    // -------------------------------------------------------------------------
    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        cyc();
        cyc();
        wr_valid = 2'b11;   // requests during reset must not be granted
        #1;
        tests++;
        if (grant_a !== 2'b00) begin
            fails++; $display("FAIL reset_grant: got %b want 00", grant_a);
        end
        tests++;
        if (tx_a.valid !== 1'b0 || ack_a !== 2'b00 || terr_a !== 1'b0) begin
            fails++; $display("FAIL reset_outs: valid=%b ack=%b terr=%b want 0/00/0",
                              tx_a.valid, ack_a, terr_a);
        end
        tests++;
        if (outs_a[0] !== 16'd0 || outs_a[1] !== 16'd0 || drained_a !== 2'b11) begin
            fails++; $display("FAIL reset_cnt: outs=%0d/%0d drained=%b want 0/0/11",
                              outs_a[0], outs_a[1], drained_a);
        end
        cyc();
        wr_valid = 2'b00;
        reset    = 1'b0;
        cyc();
        $display("[TB] test_reset done");
    endtask

    // -------------------------------------------------------------------------
    task automatic test_single();
        t_cci_c1_ReqMemHdr exp_hdr;
        do_reset();
        exp_hdr = mk_hdr(16'h0005, 42'h100);
        wr_valid = 2'b01;
        for (int k = 0; k < 5; k++) begin
            if (k < 4) wr_data[0] = 512'(100 + k);
            else       wr_valid   = 2'b00;
            #1;
            tests++;
            if (grant_a !== ((k < 4) ? 2'b01 : 2'b00)) begin
                fails++; $display("FAIL single_grant[%0d]: got %b want %b", k, grant_a,
                                  (k < 4) ? 2'b01 : 2'b00);
            end
            if (k > 0) begin
                tests++;
                if (tx_a.valid !== 1'b1 || tx_a.hdr !== exp_hdr ||
                    tx_a.data !== 512'(100 + k - 1)) begin
                    fails++; $display("FAIL single_tx[%0d]: valid=%b mdata=%h data=%0d want 1/0005/%0d",
                                      k, tx_a.valid, tx_a.hdr.mdata, tx_a.data[31:0], 100 + k - 1);
                end
            end
            cyc();
        end
        #1;
        tests++;
        if (tx_a.valid !== 1'b0 || tx_a.data !== 512'd103 || outs_a[0] !== 16'd4) begin
            fails++; $display("FAIL single_hold: valid=%b data=%0d outs=%0d want 0/103/4",
                              tx_a.valid, tx_a.data[31:0], outs_a[0]);
        end
        // Echo four acks back with the tagged mdata.
        for (int j = 0; j < 5; j++) begin
            if (j < 4) set_rsp(1'b1, eRSP_WRLINE, 16'h0005);
            else       set_rsp(1'b0, 4'h0, 16'h0000);
            #1;
            if (j > 0) begin
                tests++;
                if (ack_a !== 2'b01 || outs_a[0] !== 16'(4 - j)) begin
                    fails++; $display("FAIL single_ack[%0d]: ack=%b outs=%0d want 01/%0d",
                                      j, ack_a, outs_a[0], 4 - j);
                end
            end
            cyc();
        end
        #1;
        tests++;
        if (ack_a !== 2'b00 || outs_a[0] !== 16'd0 || drained_a[0] !== 1'b1 ||
            terr_a !== 1'b0) begin
            fails++; $display("FAIL single_drain: ack=%b outs=%0d drained=%b terr=%b want 00/0/1/0",
                              ack_a, outs_a[0], drained_a[0], terr_a);
        end
        $display("[TB] test_single done");
    endtask

    // -------------------------------------------------------------------------
    task automatic test_fairness();
        int n0, n1;
        logic [1:0] exp_g;
        n0 = 0; n1 = 0;
        do_reset();
        wr_valid = 2'b11;
        for (int k = 0; k < 9; k++) begin
            if (k == 8) wr_valid = 2'b00;
            #1;
            exp_g = (k == 8) ? 2'b00 : ((k % 2 == 0) ? 2'b01 : 2'b10);
            tests++;
            if (grant_a !== exp_g) begin
                fails++; $display("FAIL fair_grant[%0d]: got %b want %b", k, grant_a, exp_g);
            end
            if (grant_a == 2'b01) n0++;
            if (grant_a == 2'b10) n1++;
            if (k > 0) begin
                tests++;
                if (tx_a.valid !== 1'b1 ||
                    tx_a.hdr.mdata !== ((k % 2 == 1) ? 16'h0005 : 16'h1007)) begin
                    fails++; $display("FAIL fair_tag[%0d]: valid=%b mdata=%h want 1/%h", k,
                                      tx_a.valid, tx_a.hdr.mdata,
                                      (k % 2 == 1) ? 16'h0005 : 16'h1007);
                end
            end
            cyc();
        end
        tests++;
        if (n0 != 4 || n1 != 4 || outs_a[0] !== 16'd4 || outs_a[1] !== 16'd4) begin
            fails++; $display("FAIL fair_count: grants=%0d/%0d outs=%0d/%0d want 4/4/4/4",
                              n0, n1, outs_a[0], outs_a[1]);
        end
        $display("[TB] test_fairness done");
    endtask

    // -------------------------------------------------------------------------
    task automatic test_backpressure();
        logic [1:0] exp_g [10];
        exp_g = '{2'b01, 2'b10, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 2'b01, 2'b10};
        do_reset();
        wr_valid = 2'b11;
        for (int c = 0; c < 10; c++) begin
            almfull = (c >= 3 && c <= 6);
            #1;
            tests++;
            if (grant_a !== exp_g[c]) begin
                fails++; $display("FAIL bp_grant[%0d]: got %b want %b", c, grant_a, exp_g[c]);
            end
            if (c > 0) begin
                tests++;
                if (tx_a.valid !== (exp_g[c-1] != 2'b00) ||
                    (exp_g[c-1] != 2'b00 &&
                     tx_a.hdr.mdata[15:12] !== ((exp_g[c-1] == 2'b10) ? 4'd1 : 4'd0))) begin
                    fails++; $display("FAIL bp_tx[%0d]: valid=%b tag=%0d want %b/%0d", c,
                                      tx_a.valid, tx_a.hdr.mdata[15:12], exp_g[c-1] != 2'b00,
                                      (exp_g[c-1] == 2'b10) ? 1 : 0);
                end
            end
            cyc();
        end
        wr_valid = 2'b00;
        almfull  = 1'b0;
        $display("[TB] test_backpressure done");
    endtask

    // -------------------------------------------------------------------------
    task automatic test_cap();
        logic [1:0] vin   [8];
        logic [1:0] exp_g [8];
        vin   = '{2'b01, 2'b01, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11};
        exp_g = '{2'b01, 2'b01, 2'b10, 2'b10, 2'b00, 2'b00, 2'b01, 2'b00};
        do_reset();
        for (int c = 0; c < 8; c++) begin
            wr_valid = vin[c];
            if (c == 5) set_rsp(1'b1, eRSP_WRLINE, 16'h0005);
            else        set_rsp(1'b0, 4'h0, 16'h0000);
            #1;
            tests++;
            if (grant_b !== exp_g[c]) begin
                fails++; $display("FAIL cap_grant[%0d]: got %b want %b", c, grant_b, exp_g[c]);
            end
            if (c == 4) begin
                tests++;
                if (outs_b[0] !== 16'd2 || outs_b[1] !== 16'd2) begin
                    fails++; $display("FAIL cap_full: outs=%0d/%0d want 2/2", outs_b[0], outs_b[1]);
                end
            end
            if (c == 6) begin
                tests++;
                if (ack_b !== 2'b01 || outs_b[0] !== 16'd1 || terr_b !== 1'b0) begin
                    fails++; $display("FAIL cap_ack: ack=%b outs0=%0d terr=%b want 01/1/0",
                                      ack_b, outs_b[0], terr_b);
                end
            end
            cyc();
        end
        wr_valid = 2'b00;
        $display("[TB] test_cap done");
    endtask

    // -------------------------------------------------------------------------
    task automatic test_simultaneous();
        do_reset();
        wr_valid = 2'b10;
        cyc(); cyc(); cyc();
        set_rsp(1'b1, eRSP_WRLINE, 16'h1000);
        #1;
        tests++;
        if (grant_a !== 2'b10 || outs_a[1] !== 16'd3) begin
            fails++; $display("FAIL simul_pre: grant=%b outs1=%0d want 10/3", grant_a, outs_a[1]);
        end
        cyc();
        wr_valid = 2'b00;
        set_rsp(1'b0, 4'h0, 16'h0000);
        #1;
        tests++;
        if (outs_a[1] !== 16'd3 || ack_a !== 2'b10) begin
            fails++; $display("FAIL simul_post: outs1=%0d ack=%b want 3/10", outs_a[1], ack_a);
        end
        cyc();
        #1;
        tests++;
        if (ack_a !== 2'b00) begin
            fails++; $display("FAIL simul_pulse: ack=%b want 00", ack_a);
        end
        $display("[TB] test_simultaneous done");
    endtask

    // -------------------------------------------------------------------------
    // Runs straight after test_simultaneous: outstanding = {0, 3}.
    task automatic test_errors();
        // Non-write response types are ignored.
        set_rsp(1'b1, eRSP_WRFENCE, 16'h1000);
        cyc();
        set_rsp(1'b0, 4'h0, 16'h0000);
        #1;
        tests++;
        if (ack_a !== 2'b00 || outs_a[1] !== 16'd3 || terr_a !== 1'b0) begin
            fails++; $display("FAIL err_ignore: ack=%b outs1=%0d terr=%b want 00/3/0",
                              ack_a, outs_a[1], terr_a);
        end
        // Tag 5 does not exist.
        set_rsp(1'b1, eRSP_WRLINE, 16'h5000);
        cyc();
        set_rsp(1'b0, 4'h0, 16'h0000);
        #1;
        tests++;
        if (terr_a !== 1'b1 || ack_a !== 2'b00 || outs_a[0] !== 16'd0 ||
            outs_a[1] !== 16'd3) begin
            fails++; $display("FAIL err_tag5: terr=%b ack=%b outs=%0d/%0d want 1/00/0/3",
                              terr_a, ack_a, outs_a[0], outs_a[1]);
        end
        cyc();
        #1;
        tests++;
        if (terr_a !== 1'b1) begin
            fails++; $display("FAIL err_sticky: terr=%b want 1", terr_a);
        end
        // Reset clears the sticky flag.
        do_reset();
        #1;
        tests++;
        if (terr_a !== 1'b0) begin
            fails++; $display("FAIL err_reset: terr=%b want 0", terr_a);
        end
        // Ack for req0 with nothing outstanding.
        set_rsp(1'b1, eRSP_WRLINE, 16'h0005);
        cyc();
        set_rsp(1'b0, 4'h0, 16'h0000);
        #1;
        tests++;
        if (terr_a !== 1'b1 || ack_a !== 2'b00 || outs_a[0] !== 16'd0) begin
            fails++; $display("FAIL err_zero: terr=%b ack=%b outs0=%0d want 1/00/0",
                              terr_a, ack_a, outs_a[0]);
        end
        $display("[TB] test_errors done");
    endtask

    initial begin
        tests = 0;
        fails = 0;
        reset = 1'b1;
        idle_inputs();
        test_reset();
        test_single();
        test_fairness();
        test_backpressure();
        test_cap();
        test_simultaneous();
        test_errors();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pipearch_c1_arbiter.md
Name: pipearch_c1_arbiter

Overview:
- Shares the single CCI-P c1 (write) Tx/Rx channel pair between NUM_REQ independent write engines, e.g. several writeback units in a multi-engine PipeArch build.
- Grants one single-line write request per cycle, round-robin, and registers it onto af2cp_sTx_c1.
- Tags each request with the requester index in mdata, then routes each write ack back to its requester.
- Tracks outstanding writes per requester, so each engine can count its own acks and detect drain.

Parameters:
NUM_REQ, 2, number of requesters (1..16)
MAX_OUTSTANDING, 512, per-requester cap on issued-but-unacked writes
TAG_LSB, 12, lowest mdata bit of the 4-bit requester tag field (mdata[TAG_LSB+3:TAG_LSB])

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
wr_valid  in  [NUM_REQ]  requester i presents a write this cycle
wr_hdr  in  t_cci_c1_ReqMemHdr [NUM_REQ]  write header (eREQ_WRLINE_I, eCL_LEN_1, sop=1)
wr_data  in  512 [NUM_REQ]  cache-line payload
wr_grant  out  [NUM_REQ]  combinational one-hot; request i accepted this cycle
wr_ack  out  [NUM_REQ]  one-cycle pulse; one write ack for requester i
wr_outstanding  out  16 [NUM_REQ]  issued-but-unacked count
wr_drained  out  [NUM_REQ]  wr_outstanding[i]==0
tag_error  out  1  sticky; illegal or unmatched ack seen
c1TxAlmFull  in  1  CCI-P c1 Tx almost-full
cp2af_sRx_c1  in  t_if_ccip_c1_Rx  write responses
af2cp_sTx_c1  out  t_if_ccip_c1_Tx  write requests

Behaviour:
- Reset values:
  - af2cp_sTx_c1.valid=0, wr_ack=0, tag_error=0.
  - All wr_outstanding=0; round-robin pointer rr=0.
  - wr_grant is combinational, so it is 0 while reset is high.
- Eligibility: requester i is eligible when wr_valid[i] && wr_outstanding[i] < MAX_OUTSTANDING && !c1TxAlmFull && !reset.
- Arbitration:
  - Grant the first eligible index searching rr, rr+1, ... mod NUM_REQ.
  - At most one grant per cycle.
  - On grant to index g, rr <= (g+1) mod NUM_REQ. Without a grant, rr holds.
- Handshake: the requester holds wr_valid, wr_hdr and wr_data stable until wr_grant[i]. The transfer completes in the grant cycle.
- Issue latency: 1 cycle. The cycle after grant g:
  - af2cp_sTx_c1.valid=1.
  - hdr = wr_hdr[g] with mdata[TAG_LSB+3:TAG_LSB] overwritten by g; all other header fields pass through unchanged.
  - data = wr_data[g].
  - Otherwise valid=0; hdr and data hold their last value.
- c1TxAlmFull: sampled combinationally. When it is high there is no grant that cycle; the registered request already in flight still issues.
- Ack routing:
  - When cp2af_sRx_c1.rspValid && resp_type==eRSP_WRLINE: t = mdata[TAG_LSB+3:TAG_LSB].
  - If t<NUM_REQ and wr_outstanding[t]>0, pulse wr_ack[t] the next cycle.
  - Otherwise set tag_error and emit no pulse.
  - Packed responses (format=1) are out of scope; each response counts as one line.
  - Other response types are ignored.
- Counters, per requester, updated in the grant/response cycle:
  - +1 on grant.
  - −1 on a valid routed ack.
  - Both in the same cycle leaves the counter unchanged.
  - No wrap: a requester is never granted at the cap, and decrement at 0 is flagged as tag_error rather than applied.
- Reset mid-operation: all state clears. Acks for writes issued before reset arrive as unmatched, set tag_error, and are dropped. The system resets the AFU as a whole, so this case is benign.
- NUM_REQ=1: the tag is always 0, rr is constant, and the arbiter degenerates to a registered pass-through with ack counting.

Test Plan:
- Single requester:
  - NUM_REQ=2; req0 streams 4 writes with mdata=0x0005, req1 idle.
  - Expect wr_grant[0] on 4 consecutive cycles and Tx valid 1 cycle after each, with mdata[15:12]=0, mdata[11:0]=0x005.
  - 4 acks echoed back: 4 wr_ack[0] pulses, then wr_outstanding[0] 4→0 and wr_drained[0]=1.
- Fairness: both requesters valid continuously for 8 cycles from reset → grants alternate 0,1,0,1,..., 4 each; Tx tags alternate 0,1.
- Backpressure:
  - Assert c1TxAlmFull for cycles 3–6 during a stream.
  - Expect no wr_grant in those cycles and the request granted in cycle 2 still issued in cycle 3.
  - Grants resume in cycle 7, starting from the index after the last grant.
- Cap:
  - MAX_OUTSTANDING=2, no acks: req0 granted twice, then blocked while req1 keeps being granted.
  - One ack for req0 → req0 is granted again.
- Simultaneous grant and ack to req1 with wr_outstanding[1]=3 → stays 3; wr_ack[1] pulses next cycle.
- Errors:
  - Ack with tag 5 at NUM_REQ=2 → tag_error=1, no wr_ack, counters unchanged.
  - Ack for req0 while its count is 0 → tag_error stays 1.
  - reset clears tag_error.
